// File: rtl/win_detector.sv
// Board-RAM reader that decides whether the stone just placed at (x, y) completes
// a run of WIN_LEN stones, scanning the four line directions through a 1-cycle-latency read port.
module win_detector #(
    parameter int BOARD_SIZE = 15,
    parameter int ADDR_W     = 8,
    parameter int WIN_LEN    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        x_in,
    input  logic [3:0]        y_in,
    input  logic [1:0]        player,
    input  logic [1:0]        mem_q,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic [1:0]        win_dir
);
    localparam int CW = $clog2(WIN_LEN + 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] STEP_LAST = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0] CNT_WIN   = CW'(WIN_LEN - 2);
    localparam logic signed [5:0] BS_S  = 6'(BOARD_SIZE);

    typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      x_reg, x_next, y_reg, y_next;
    logic [1:0]      player_reg, player_next;
    logic [1:0]      dir_reg, dir_next;
    logic            sign_reg, sign_next;   // 0: positive half-ray, 1: negative
    logic [CW-1:0]   step_reg, step_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            win_reg, win_next;
    logic [1:0]      win_dir_reg, win_dir_next;

    logic signed [5:0] x_s, y_s, step_s, off;
    logic signed [5:0] tx_d [4];
    logic signed [5:0] ty_d [4];
    logic signed [5:0] tx_sel, ty_sel;
    logic              in_bounds;
    logic              end_ray;
    logic [ADDR_W-1:0] addr_calc;

    assign x_s    = $signed({2'b00, x_reg});
    assign y_s    = $signed({2'b00, y_reg});
    assign step_s = $signed({{(6-CW){1'b0}}, step_reg});
    assign off    = sign_reg ? -step_s : step_s;

    // Direction vectors: 0 (+1,0), 1 (0,+1), 2 (+1,+1), 3 (+1,-1)
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir
            localparam int DX = (gi == 1) ? 0 : 1;
            localparam int DY = (gi == 0) ? 0 : ((gi == 3) ? -1 : 1);
            assign tx_d[gi] = (DX == 0) ? x_s : x_s + off;
            assign ty_d[gi] = (DY == 0) ? y_s : ((DY > 0) ? y_s + off : y_s - off);
        end
    endgenerate

    assign tx_sel    = tx_d[dir_reg];
    assign ty_sel    = ty_d[dir_reg];
    assign in_bounds = (tx_sel >= 6'sd0) && (tx_sel < BS_S) &&
                       (ty_sel >= 6'sd0) && (ty_sel < BS_S);
    assign addr_calc = ADDR_W'(ty_sel[3:0]) * ADDR_W'(BOARD_SIZE) + ADDR_W'(tx_sel[3:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            player_reg  <= '0;
            dir_reg     <= '0;
            sign_reg    <= 1'b0;
            step_reg    <= '0;
            count_reg   <= '0;
            win_reg     <= 1'b0;
            win_dir_reg <= '0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            player_reg  <= player_next;
            dir_reg     <= dir_next;
            sign_reg    <= sign_next;
            step_reg    <= step_next;
            count_reg   <= count_next;
            win_reg     <= win_next;
            win_dir_reg <= win_dir_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        player_next  = player_reg;
        dir_next     = dir_reg;
        sign_next    = sign_reg;
        step_next    = step_reg;
        count_next   = count_reg;
        win_next     = win_reg;
        win_dir_next = win_dir_reg;
        mem_rd_en    = 1'b0;
        end_ray      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    x_next       = x_in;
                    y_next       = y_in;
                    player_next  = player;
                    dir_next     = 2'd0;
                    sign_next    = 1'b0;
                    step_next    = ONE;
                    count_next   = '0;
                    win_next     = 1'b0;
                    win_dir_next = 2'd0;
                    state_next   = (player == 2'b00 || player == 2'b11) ? DONE : READ;
                end
            end
            READ: begin
                if (in_bounds) begin
                    mem_rd_en  = 1'b1;
                    state_next = CMP;
                end else begin
                    end_ray = 1'b1;
                end
            end
            CMP: begin
                if (mem_q == player_reg) begin
                    count_next = count_reg + ONE;
                    // Origin stone plus this neighbor completes the run
                    if (count_reg == CNT_WIN) begin
                        win_next     = 1'b1;
                        win_dir_next = dir_reg;
                        state_next   = DONE;
                    end else begin
                        step_next = step_reg + ONE;
                        if (step_reg >= STEP_LAST) end_ray = 1'b1;
                        else                       state_next = READ;
                    end
                end else begin
                    end_ray = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (end_ray) begin
            step_next = ONE;
            if (!sign_reg) begin
                sign_next  = 1'b1;
                state_next = READ;
            end else if (dir_reg == 2'd3) begin
                state_next = DONE;
            end else begin
                dir_next   = dir_reg + 2'd1;
                sign_next  = 1'b0;
                count_next = '0;
                state_next = READ;
            end
        end
    end

    assign mem_addr = mem_rd_en ? addr_calc : '0;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign win      = win_reg;
    assign win_dir  = win_dir_reg;
endmodule

// File: tb/tb_win_detector.sv
// Bench for win_detector: behavioural board model, directed test-plan scans,
// randomized boards, invalid-player, reset-abort and start-while-busy checks.
module tb_win_detector;
    localparam int BS = 15;
    localparam int WL = 5;

    logic       clock, reset, start;
    logic [3:0] x_in, y_in;
    logic [1:0] player, mem_q;
    logic       mem_rd_en, busy, done, win;
    logic [7:0] mem_addr;
    logic [1:0] win_dir;

    win_detector #(.BOARD_SIZE(BS), .ADDR_W(8), .WIN_LEN(WL)) dut (
        .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .player(player), .mem_q(mem_q), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .busy(busy), .done(done), .win(win), .win_dir(win_dir)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] board [BS*BS];
    int rd_log[$];
    int exp_addr[$];
    int exp_win, exp_dir, exp_cyc;
    int total = 0, bad = 0;

    // RAM read port with one cycle of latency, plus a log of issued addresses
    always @(posedge clock) begin
        if (mem_rd_en === 1'b1) begin
            mem_q <= board[mem_addr];
            rd_log.push_back(int'(mem_addr));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < BS*BS; i++) board[i] = 2'b00;
    endtask

    task automatic put(input int x, input int y, input logic [1:0] c);
        board[y*BS + x] = c;
    endtask

    // Reference: walk each direction as two half-rays; an in-board probe costs
    // 2 cycles, an off-board probe 1 cycle; done lands one cycle after the scan.
    task automatic model(input int x, input int y, input int p);
        int dxs[4] = '{1, 0, 1, 1};
        int dys[4] = '{0, 1, 1, -1};
        int cyc, cnt, tx, ty, sgn;
        bit finished, stop;
        exp_addr.delete();
        exp_win = 0; exp_dir = 0; cyc = 0; finished = 0;
        if (p != 1 && p != 2) finished = 1;
        for (int d = 0; d < 4 && !finished; d++) begin
            cnt = 0;
            for (int h = 0; h < 2 && !finished; h++) begin
                sgn = (h == 0) ? 1 : -1;
                stop = 0;
                for (int k = 1; k < WL && !stop && !finished; k++) begin
                    tx = x + sgn*k*dxs[d];
                    ty = y + sgn*k*dys[d];
                    if (tx < 0 || tx >= BS || ty < 0 || ty >= BS) begin
                        cyc += 1;
                        stop = 1;
                    end else begin
                        cyc += 2;
                        exp_addr.push_back(ty*BS + tx);
                        if (int'(board[ty*BS + tx]) == p) begin
                            cnt++;
                            if (cnt + 1 >= WL) begin
                                exp_win = 1; exp_dir = d; finished = 1;
                            end
                        end else begin
                            stop = 1;
                        end
                    end
                end
            end
        end
        exp_cyc = cyc + 1;
    endtask

    task automatic run_scan(input string tag, input int x, input int y, input int p);
        int k;
        bit addr_ok;
        int w_hold, d_hold;
        if (p == 1 || p == 2) put(x, y, 2'(p));
        model(x, y, p);
        rd_log.delete();
        @(negedge clock);
        start = 1'b1; x_in = 4'(x); y_in = 4'(y); player = 2'(p);
        @(negedge clock);
        start = 1'b0;
        k = 1;
        check({tag, ":busy"}, busy, 1);
        while (done !== 1'b1 && k < 300) begin
            @(negedge clock);
            k++;
        end
        check({tag, ":done_cycle"}, k, exp_cyc);
        check({tag, ":win"}, win, exp_win);
        check({tag, ":win_dir"}, win_dir, exp_dir);
        check({tag, ":reads"}, rd_log.size(), exp_addr.size());
        addr_ok = (rd_log.size() == exp_addr.size());
        for (int i = 0; i < rd_log.size() && addr_ok; i++)
            if (rd_log[i] != exp_addr[i]) addr_ok = 0;
        check({tag, ":addr_seq"}, addr_ok, 1);
        w_hold = exp_win; d_hold = exp_dir;
        @(negedge clock);
        check({tag, ":done_pulse"}, done, 0);
        check({tag, ":idle"}, busy, 0);
        check({tag, ":win_held"}, win, w_hold);
        $display("scan %s x=%0d y=%0d p=%0d cycle=%0d win=%0d dir=%0d reads=%0d",
                 tag, x, y, p, k, win, win_dir, rd_log.size());
    endtask

    initial begin
        int dn, k;
        reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0; player = '0;
        clear_board();
        repeat (3) @(negedge clock);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:win", win, 0);
        check("rst:win_dir", win_dir, 0);
        check("rst:rd_en", mem_rd_en, 0);
        check("rst:addr", mem_addr, 0);
        reset = 1'b0;
        @(negedge clock);

        // Isolated stone: all eight half-rays miss at step 1
        clear_board();
        run_scan("isolated", 7, 7, 1);
        check("isolated:cyc17", k_dummy(exp_cyc), 17);

        // Horizontal run to the right
        clear_board();
        for (int i = 8; i <= 11; i++) put(i, 7, 2'b01);
        run_scan("horiz_pos", 7, 7, 1);

        // Run split across both halves, blocked by white
        clear_board();
        put(5, 7, 2'b01); put(6, 7, 2'b01); put(8, 7, 2'b01); put(9, 7, 2'b01);
        put(10, 7, 2'b10);
        run_scan("horiz_split", 7, 7, 1);

        // Corner: off-board half-rays cost no read
        clear_board();
        run_scan("corner", 0, 0, 1);

        // Anti-diagonal white win
        clear_board();
        put(4, 10, 2'b10); put(5, 9, 2'b10); put(6, 8, 2'b10); put(2, 12, 2'b10);
        run_scan("anti_diag", 3, 11, 2);

        // Four black with a white gap before the fifth: no win
        clear_board();
        for (int i = 8; i <= 10; i++) put(i, 7, 2'b01);
        put(11, 7, 2'b10); put(12, 7, 2'b01);
        run_scan("gap", 7, 7, 1);

        // Edge run where the line touches the last column
        clear_board();
        for (int i = 10; i <= 13; i++) put(i, 14, 2'b10);
        run_scan("edge", 14, 14, 2);

        // Invalid colors finish immediately
        clear_board();
        run_scan("illegal", 7, 7, 3);
        run_scan("empty", 7, 7, 0);

        // Randomized boards of varying density
        for (int t = 0; t < 40; t++) begin
            int x, y, p, r, dens;
            x = $urandom_range(0, BS-1);
            y = $urandom_range(0, BS-1);
            p = $urandom_range(1, 2);
            dens = $urandom_range(1, 6);
            for (int i = 0; i < BS*BS; i++) begin
                r = $urandom_range(0, 7);
                board[i] = (r < dens) ? 2'(p) : ((r == 7) ? 2'(3 - p) : 2'b00);
            end
            run_scan("rand", x, y, p);
        end

        // Reset mid-scan: aborts with no done pulse
        clear_board();
        @(negedge clock);
        start = 1'b1; x_in = 4'd7; y_in = 4'd7; player = 2'b01;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rstmid:rd_en", mem_rd_en, 0);
        check("rstmid:busy", busy, 0);
        check("rstmid:win", win, 0);
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
        end
        check("rstmid:no_done", dn, 0);
        $display("scan rst_mid done_pulses=%0d", dn);

        // Start while busy is ignored
        clear_board();
        @(negedge clock);
        start = 1'b1; x_in = 4'd7; y_in = 4'd7; player = 2'b01;
        @(negedge clock);
        start = 1'b0;
        dn = 0; k = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin
                start = 1'b1; x_in = 4'd0; y_in = 4'd0; player = 2'b10;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dn++;
                if (k == 0) k = c;
            end
            @(negedge clock);
        end
        check("busy_start:done_count", dn, 1);
        check("busy_start:done_cycle", k, 17);
        $display("scan busy_start done_pulses=%0d cycle=%0d", dn, k);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Model sanity anchor for the isolated case: the bench's own cost rule must give 17
    function automatic int k_dummy(input int v);
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
